// File: rtl/lag_monitored_link_pkg.sv
// Shared types for the LAG mesh link: flit layout, hop-field limit and flit-ID width.
package lag_monitored_link_pkg;

    localparam int unsigned HopW    = 4;
    localparam int unsigned FlitIdW = 8;
    localparam int unsigned DataW   = 16;

    localparam logic [HopW-1:0] HopMax = '1;

    typedef struct packed {
        logic valid;
        logic head;
        logic tail;
    } flit_ctrl_t;

    typedef struct packed {
        logic [HopW-1:0] hops;
    } flit_debug_t;

    typedef struct packed {
        flit_ctrl_t         control;
        flit_debug_t        debug;
        logic [FlitIdW-1:0] flit_id;
        logic [DataW-1:0]   payload;
    } flit_t;

    // Valid flits gain one hop, saturating; everything else passes untouched.
    function automatic flit_t hop_adjust(flit_t f);
        flit_t r;
        r = f;
        if (f.control.valid && (f.debug.hops != HopMax)) begin
            r.debug.hops = f.debug.hops + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lag_monitored_link_if.sv
// Bundle of link-facing signals; slave is the link itself, master is the surrounding fabric.
interface lag_monitored_link_if
    import lag_monitored_link_pkg::*;
#(
    parameter int unsigned NPC    = 2,
    parameter int unsigned UTIL_W = 32
);
    flit_t [NPC-1:0]              data_in;
    flit_t [NPC-1:0]              data_out;
    logic  [NPC-1:0]              ctrl_in;
    logic  [NPC-1:0]              ctrl_out;
    logic  [NPC-1:0][UTIL_W-1:0]  util_live;
    logic  [NPC-1:0][UTIL_W-1:0]  util_snap;
    logic                         snap_valid;
    logic  [NPC-1:0]              seq_err;
    logic                         err_clr;

    modport master (
        output data_in, ctrl_in, err_clr,
        input  data_out, ctrl_out, util_live, util_snap, snap_valid, seq_err
    );

    modport slave (
        input  data_in, ctrl_in, err_clr,
        output data_out, ctrl_out, util_live, util_snap, snap_valid, seq_err
    );
endinterface

// File: rtl/lag_link_seq_checker.sv
// Per-channel flit-ID sequence checker with sticky error and windowed utilisation counter.
module lag_link_seq_checker
    import lag_monitored_link_pkg::*;
#(
    parameter int unsigned UTIL_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_i,
    input  logic               tail_i,
    input  logic [FlitIdW-1:0] id_i,
    input  logic               win_end_i,
    input  logic               err_clr_i,
    output logic               seq_err_o,
    output logic [UTIL_W-1:0]  util_live_o,
    output logic [UTIL_W-1:0]  util_snap_o
);
    logic [FlitIdW-1:0] exp_q, exp_d;
    logic               err_q, err_d;
    logic [UTIL_W-1:0]  live_q, live_d, snap_q, snap_d, live_inc;

    always_comb begin
        exp_d    = exp_q;
        err_d    = err_q;
        snap_d   = snap_q;
        live_inc = (valid_i && (live_q != '1)) ? live_q + 1'b1 : live_q;
        live_d   = live_inc;
        if (err_clr_i) err_d = 1'b0;
        // A fresh error overrides a same-cycle clear; resync follows the received ID.
        if (valid_i) begin
            if (id_i != exp_q) err_d = 1'b1;
            exp_d = tail_i ? FlitIdW'(1) : id_i + 1'b1;
        end
        if (win_end_i) begin
            snap_d = live_inc;
            live_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q  <= FlitIdW'(1);
            err_q  <= 1'b0;
            live_q <= '0;
            snap_q <= '0;
        end else begin
            exp_q  <= exp_d;
            err_q  <= err_d;
            live_q <= live_d;
            snap_q <= snap_d;
        end
    end

    assign seq_err_o   = err_q;
    assign util_live_o = live_q;
    assign util_snap_o = snap_q;
endmodule

// File: rtl/lag_monitored_link.sv
// Pipelined multi-channel router link with hop increment, credit return and per-channel monitors.
module lag_monitored_link
    import lag_monitored_link_pkg::*;
#(
    parameter int unsigned NPC          = 2,
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned CTRL_LATENCY = 1,
    parameter int unsigned UTIL_W       = 32,
    parameter int unsigned WINDOW       = 1024
) (
    input logic                 clk,
    input logic                 rst_n,
    lag_monitored_link_if.slave link
);
    localparam int unsigned WinW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    flit_t [NPC-1:0]   data_pipe;
    logic  [NPC-1:0]   ctrl_pipe;
    logic  [WinW-1:0]  win_q, win_d;
    logic              win_end;
    logic              snap_valid_q;
    logic [UTIL_W-1:0] live [NPC];
    logic [UTIL_W-1:0] snap [NPC];
    logic [NPC-1:0]    err;

    if (LATENCY == 0) begin : g_data_comb
        assign data_pipe = link.data_in;
    end else begin : g_data_pipe
        flit_t [NPC-1:0] stage_q [LATENCY];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned s = 0; s < LATENCY; s++) stage_q[s] <= '0;
            end else begin
                stage_q[0] <= link.data_in;
                for (int unsigned s = 1; s < LATENCY; s++) stage_q[s] <= stage_q[s-1];
            end
        end
        assign data_pipe = stage_q[LATENCY-1];
    end

    if (CTRL_LATENCY == 0) begin : g_ctrl_comb
        assign ctrl_pipe = link.ctrl_in;
    end else begin : g_ctrl_pipe
        logic [NPC-1:0] cstage_q [CTRL_LATENCY];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned s = 0; s < CTRL_LATENCY; s++) cstage_q[s] <= '0;
            end else begin
                cstage_q[0] <= link.ctrl_in;
                for (int unsigned s = 1; s < CTRL_LATENCY; s++) cstage_q[s] <= cstage_q[s-1];
            end
        end
        assign ctrl_pipe = cstage_q[CTRL_LATENCY-1];
    end

    // WINDOW of 0 keeps the counter parked and never ends a window.
    always_comb begin
        win_end = (WINDOW != 0) && (win_q == WinW'(WINDOW - 1));
        win_d   = win_q;
        if (win_end)          win_d = '0;
        else if (WINDOW != 0) win_d = win_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q        <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            win_q        <= win_d;
            snap_valid_q <= win_end;
        end
    end

    for (genvar c = 0; c < NPC; c++) begin : g_chan
        lag_link_seq_checker #(
            .UTIL_W (UTIL_W)
        ) u_checker (
            .clk         (clk),
            .rst_n       (rst_n),
            .valid_i     (link.data_in[c].control.valid),
            .tail_i      (link.data_in[c].control.tail),
            .id_i        (link.data_in[c].flit_id),
            .win_end_i   (win_end),
            .err_clr_i   (link.err_clr),
            .seq_err_o   (err[c]),
            .util_live_o (live[c]),
            .util_snap_o (snap[c])
        );
    end

    always_comb begin
        link.data_out = '0;
        link.util_live = '0;
        link.util_snap = '0;
        for (int c = 0; c < NPC; c++) begin
            link.data_out[c]  = hop_adjust(data_pipe[c]);
            link.util_live[c] = live[c];
            link.util_snap[c] = snap[c];
        end
    end

    assign link.ctrl_out   = ctrl_pipe;
    assign link.seq_err    = err;
    assign link.snap_valid = snap_valid_q;
endmodule

// File: tb/tb_lag_monitored_link.sv
// Directed bench for two link configurations sharing one stimulus stream, with an output scoreboard.
module tb_lag_monitored_link;
    import lag_monitored_link_pkg::*;

    localparam int unsigned LatA = 3;

    typedef struct {
        int unsigned due;
        int          ch;
        flit_t       f;
    } sb_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    flit_t [1:0]     din;
    logic  [1:0]     cin;
    logic            eclr;
    int unsigned     cyc;
    int unsigned     n_checks = 0;
    int unsigned     n_pass = 0;
    int unsigned     n_fail = 0;
    logic            b_snap_seen = 1'b0;
    sb_t             sb[$];

    lag_monitored_link_if #(.NPC(2), .UTIL_W(32)) ifa ();
    lag_monitored_link_if #(.NPC(2), .UTIL_W(4))  ifb ();

    assign ifa.data_in = din;
    assign ifb.data_in = din;
    assign ifa.ctrl_in = cin;
    assign ifb.ctrl_in = cin;
    assign ifa.err_clr = eclr;
    assign ifb.err_clr = eclr;

    lag_monitored_link #(
        .NPC(2), .LATENCY(LatA), .CTRL_LATENCY(1), .UTIL_W(32), .WINDOW(16)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (ifa.slave)
    );

    lag_monitored_link #(
        .NPC(2), .LATENCY(0), .CTRL_LATENCY(2), .UTIL_W(4), .WINDOW(0)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (ifb.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge rst_n) sb.delete();

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic flit_t exp_flit(flit_t f);
        flit_t r;
        r = f;
        if (f.control.valid) r.debug.hops = (f.debug.hops == 4'hF) ? 4'hF : f.debug.hops + 4'd1;
        return r;
    endfunction

    function automatic flit_t mk(input logic [7:0] id, input logic tail, input logic [3:0] hops);
        flit_t f;
        f = '0;
        f.control.valid = 1'b1;
        f.control.tail  = tail;
        f.debug.hops    = hops;
        f.flit_id       = id;
        f.payload       = {id, ~id};
        return f;
    endfunction

    task automatic drive(input flit_t f0, input flit_t f1);
        din[0] = f0;
        din[1] = f1;
        if (f0.control.valid) sb.push_back('{cyc + LatA, 0, exp_flit(f0)});
        if (f1.control.valid) sb.push_back('{cyc + LatA, 1, exp_flit(f1)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) step();
        chk("sb_drain", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard: LATENCY=3 link compared against queued expectations, LATENCY=0 link against din.
    always @(negedge clk) begin
        flit_t [1:0] exp_a;
        sb_t         e;
        exp_a = '0;
        while (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            exp_a[e.ch] = e.f;
        end
        if (sb.size() != 0 && sb[0].due < cyc) begin
            chk("sb_overdue", 64'(sb[0].due), 64'(cyc));
            void'(sb.pop_front());
        end
        chk("a_data_out", 64'(ifa.data_out), 64'(exp_a));
        chk("b_data_out", 64'(ifb.data_out), 64'({exp_flit(din[1]), exp_flit(din[0])}));
        if (ifb.snap_valid) b_snap_seen = 1'b1;
    end

    initial begin
        din  = '0;
        cin  = '0;
        eclr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_data", 64'(ifa.data_out), 64'd0);
        chk("rst_a_ctrl", 64'(ifa.ctrl_out), 64'd0);
        chk("rst_a_live", 64'(ifa.util_live), 64'd0);
        chk("rst_a_snap", 64'(ifa.util_snap), 64'd0);
        chk("rst_a_snapv", 64'(ifa.snap_valid), 64'd0);
        chk("rst_a_err", 64'(ifa.seq_err), 64'd0);
        chk("rst_b_ctrl", 64'(ifb.ctrl_out), 64'd0);
        chk("rst_b_live", 64'(ifb.util_live), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Window and saturation: 20 back-to-back valid flits on channel 0 from cycle 0.
        for (int k = 0; k < 20; k++) begin
            drive(mk(8'(k + 1), 1'b0, 4'(k % 4)), '0);
            @(negedge clk);
            if (k == 15) chk("a_snapv_c15", 64'(ifa.snap_valid), 64'd0);
            if (k == 15) chk("b_live_c15", 64'(ifb.util_live[0]), 64'd15);
            if (k == 16) begin
                chk("a_snapv_c16", 64'(ifa.snap_valid), 64'd1);
                chk("a_snap_c16", 64'(ifa.util_snap), {32'd0, 32'd16});
                chk("a_live_c16", 64'(ifa.util_live[0]), 64'd0);
            end
            if (k == 17) begin
                chk("a_snapv_c17", 64'(ifa.snap_valid), 64'd0);
                chk("a_live_c17", 64'(ifa.util_live[0]), 64'd1);
            end
            if (k == 19) begin
                chk("a_live_c19", 64'(ifa.util_live[0]), 64'd3);
                chk("b_live_sat", 64'(ifb.util_live[0]), 64'd15);
            end
            step();
        end

        // Close the packet, then IDs 1,2,3(tail) with hop saturation at field max.
        drive(mk(8'd21, 1'b1, 4'hF), '0);
        step();
        drive(mk(8'd1, 1'b0, 4'd2), '0);
        step();
        drive(mk(8'd2, 1'b0, 4'd14), '0);
        step();
        drive(mk(8'd3, 1'b1, 4'hF), '0);
        step();
        din = '0;
        drain();
        chk("seq_ok_ch0", 64'(ifa.seq_err), 64'd0);

        // Control return path.
        cin = 2'b01;
        @(negedge clk);
        chk("ctrl_a_t0", 64'(ifa.ctrl_out), 64'd0);
        chk("ctrl_b_t0", 64'(ifb.ctrl_out), 64'd0);
        step();
        cin = 2'b00;
        @(negedge clk);
        chk("ctrl_a_t1", 64'(ifa.ctrl_out), 64'b01);
        chk("ctrl_b_t1", 64'(ifb.ctrl_out), 64'd0);
        step();
        @(negedge clk);
        chk("ctrl_a_t2", 64'(ifa.ctrl_out), 64'd0);
        chk("ctrl_b_t2", 64'(ifb.ctrl_out), 64'b01);
        step();
        @(negedge clk);
        chk("ctrl_b_t3", 64'(ifb.ctrl_out), 64'd0);

        // Channel 1 sequence: 1, 3, 4(tail), 1.
        step();
        drive('0, mk(8'd1, 1'b0, 4'd0));
        @(negedge clk);
        chk("seq_s0", 64'(ifa.seq_err), 64'd0);
        step();
        drive('0, mk(8'd3, 1'b0, 4'd0));
        @(negedge clk);
        chk("seq_s1", 64'(ifa.seq_err), 64'd0);
        step();
        drive('0, mk(8'd4, 1'b1, 4'd0));
        @(negedge clk);
        chk("seq_s2_err", 64'(ifa.seq_err), 64'b10);
        step();
        drive('0, mk(8'd1, 1'b0, 4'd0));
        @(negedge clk);
        chk("seq_s3_sticky", 64'(ifa.seq_err), 64'b10);
        step();
        din  = '0;
        eclr = 1'b1;
        @(negedge clk);
        chk("seq_s4_noerr", 64'(ifa.seq_err), 64'b10);
        step();
        drive('0, mk(8'd9, 1'b0, 4'd0));
        @(negedge clk);
        chk("seq_clr", 64'(ifa.seq_err), 64'd0);
        chk("seq_clr_b", 64'(ifb.seq_err), 64'd0);
        step();
        din  = '0;
        eclr = 1'b0;
        @(negedge clk);
        chk("seq_err_wins", 64'(ifa.seq_err), 64'b10);
        drain();

        // Mid-stream reset with flits in flight on channel 0.
        for (int k = 1; k <= 4; k++) begin
            drive(mk(8'(k), 1'b0, 4'd0), '0);
            step();
        end
        chk("pre_rst_valid", 64'(ifa.data_out[0].control.valid), 64'd1);
        rst_n = 1'b0;
        din   = '0;
        #1;
        chk("rst_valid_low", 64'(ifa.data_out[0].control.valid), 64'd0);
        chk("rst_err", 64'(ifa.seq_err), 64'd0);
        chk("rst_live", 64'(ifa.util_live), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(mk(8'd1, 1'b0, 4'd0), '0);
        step();
        din = '0;
        @(negedge clk);
        chk("post_rst_seq", 64'(ifa.seq_err), 64'd0);
        chk("post_rst_live", 64'(ifa.util_live[0]), 64'd1);
        drain();
        chk("b_snap_never", 64'(b_snap_seen), 64'd0);
        chk("b_snap_zero", 64'(ifb.util_snap), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/lag_monitored_link.md
# lag_monitored_link

Parametrised router-to-router link for the LAG mesh: carries `NPC` parallel physical channels of `flit_t` through a configurable-depth register pipeline and returns per-channel flow-control bits through an independent configurable-depth pipeline. It increments hop counts at the link output. It also keeps windowed per-channel utilisation counters and checks per-channel flit-ID sequences in hardware; errors are flagged and the checker resynchronises, with no simulation-only `$finish`. It sits between a router output port and the neighbouring router input port.

## Interface
- `NPC`, 2, number of physical channels on the link (≥1)
- `LATENCY`, 1, data pipeline stages (0–8); 0 = combinational pass-through
- `CTRL_LATENCY`, 1, control-return pipeline stages (0–8)
- `UTIL_W`, 32, utilisation counter width
- `WINDOW`, 1024, sampling window in cycles; 0 = free-running, no snapshots
- `clk`  in  1  link clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `data_in`  in  `flit_t [NPC]`  flits from upstream router output
- `data_out`  out  `flit_t [NPC]`  flits to downstream router input, hops adjusted
- `ctrl_in`  in  `NPC`  credit/control bits from downstream router
- `ctrl_out`  out  `NPC`  delayed control bits to upstream router
- `util_live`  out  `UTIL_W [NPC]`  valid-flit count in current window
- `util_snap`  out  `UTIL_W [NPC]`  count of last completed window
- `snap_valid`  out  1  one-cycle pulse when `util_snap` updates
- `seq_err`  out  `NPC`  sticky sequence-error flag per channel
- `err_clr`  in  1  clears all `seq_err` bits

## Operation
- Data path: per channel, `LATENCY` flit registers. Every stage loads every cycle; there is no stall, because credit control lives upstream.
- Hop adjust: at the output, if `control.valid`, then `debug.hops` = input hops + 1, saturating at field max. Non-valid flits pass unmodified.
- Control path: `CTRL_LATENCY` registers per bit, independent of the data path.
- Utilisation: on each cycle with `data_in[c].control.valid`, `util_live[c]` increments and saturates at 2^UTIL_W−1.
- Window counter: runs 0..WINDOW−1.
  - On the cycle the counter equals WINDOW−1, `util_snap[c]` ← `util_live[c]` plus that cycle's flit.
  - In the same cycle, `util_live[c]` ← 0 and `snap_valid` = 1 on the next edge; the counter wraps to 0.
  - `WINDOW`=0: no wrap, `snap_valid` stays 0, `util_snap` stays 0.
- Sequence check: sampled at `data_in`, so it is independent of latency. `expected[c]` resets to 1. On a valid flit:
  - If `flit_id != expected[c]`, set `seq_err[c]`.
  - Then `expected[c]` ← 1 if `control.tail`, else `flit_id + 1`. This resynchronises on the received ID, not on the old expected value.
- `err_clr` with a new error on the same channel in the same cycle: the error wins and `seq_err` stays 1.

## Timing
- Reset values:
  - All pipeline stages '0, so `data_out` is '0 (valid low) and `ctrl_out` is 0.
  - `util_live`, `util_snap`, window counter: 0.
  - `snap_valid`, `seq_err`: 0.
  - `expected`: 1.
- Data latency: a flit at `data_in` in cycle t appears at `data_out` in cycle t+`LATENCY`. Control latency is t+`CTRL_LATENCY`. Throughput is 1 flit/channel/cycle.
- `seq_err[c]` and `util_live[c]` reflect a flit sampled in cycle t from cycle t+1.
- `snap_valid` is high exactly one cycle, every `WINDOW` cycles, first at cycle `WINDOW` after reset release.
- `err_clr` takes effect on the next edge.
- Reset asserted mid-operation: in-flight flits and credits are dropped; all state returns to reset values asynchronously.

## Structure
- Shared package: `flit_t`, the hop-field max constant, and the flit-ID width. `flit_t` is reused unchanged.
- Sub-module `lag_link_seq_checker`: one per channel, holding `expected`, the sticky error, and the utilisation counter.
- Top level: generate loops over the channels and pipeline stages, plus the shared window counter.

## Test plan
- `LATENCY`=3, `NPC`=2: flits with IDs 1,2,3(tail) on channel 0 at cycles 10–12 → appear at `data_out` at cycles 13–15 with hops+1; `seq_err`=0.
- `LATENCY`=0, `CTRL_LATENCY`=2: `ctrl_in`=2'b01 at cycle 5 → `ctrl_out`=2'b01 at cycle 7; data passes combinationally in the same cycle.
- Channel 1 receives IDs 1,3,4(tail),1 → `seq_err[1]`=1 one cycle after ID 3 and no further error; `err_clr` → 0. `err_clr` in the same cycle as a new error → stays 1.
- `WINDOW`=16: continuous valid on channel 0, none on channel 1 → `snap_valid` pulses at cycle 16 after reset, `util_snap`={16,0}, `util_live` restarts at 0.
- `UTIL_W`=4, `WINDOW`=0: 20 consecutive valid flits → `util_live` saturates at 15; `snap_valid` never asserts.
- Flit with `debug.hops` at field max → output hops unchanged at max. `rst_n` pulsed low mid-stream → `data_out` valid low immediately; `expected` back to 1, so a next ID of 1 raises no error.
